// File: rtl/code_entry_verifier_pkg.sv
// ---------------------------------------------------------------------------
// code_entry_verifier_pkg
// Shared definitions for the code entry verifier:
//   state_t         - FSM state encoding (3 bits)
//   CODE_DIGITS     - number of keypad nibbles in one code
//   scramble_code   - nibble permutation applied by the stored-code register
//   unscramble_code - its inverse, used by the verifier in CHECK
// The two functions live side by side so a change to one is made to both.
// ---------------------------------------------------------------------------
package code_entry_verifier_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_GRANT   = 3'd3,
    S_DENY    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  localparam int CODE_DIGITS = 4;
  localparam int CODE_W      = 4 * CODE_DIGITS;

  // Stored form: plain code rotated left by one nibble.
  function automatic logic [CODE_W-1:0] scramble_code(input logic [CODE_W-1:0] plain);
    return {plain[CODE_W-5:0], plain[CODE_W-1:CODE_W-4]};
  endfunction

  // Rotate right by one nibble to recover the plain code.
  function automatic logic [CODE_W-1:0] unscramble_code(input logic [CODE_W-1:0] stored);
    return {stored[3:0], stored[CODE_W-1:4]};
  endfunction

endpackage

// File: rtl/code_entry_verifier_if.sv
// ---------------------------------------------------------------------------
// code_entry_verifier_if
// Bundles the keypad-side inputs, the stored code and the status outputs.
//   master : keypad/debouncer + stored-code register side (drives inputs)
//   slave  : the verifier (drives unlock/fail/locked_out/busy/counters)
//
// Handshake: digit_valid is a one-cycle strobe with an implicit ready equal
// to !busy. A digit is taken at a rising edge where digit_valid is high,
// clear is low and busy is low; a strobe while busy is high is dropped and
// never retried by the verifier. clear has the same acceptance window and
// wins over a coincident digit_valid.
// dbg_state exposes the FSM state for checkers.
// ---------------------------------------------------------------------------
interface code_entry_verifier_if;
  import code_entry_verifier_pkg::*;

  logic              digit_valid;
  logic [3:0]        digit;
  logic              clear;
  logic [CODE_W-1:0] stored_code;
  logic              unlock;
  logic              fail;
  logic              locked_out;
  logic              busy;
  logic [2:0]        digit_count;
  logic [1:0]        fail_count;
  state_t            dbg_state;

  modport master (
    output digit_valid, digit, clear, stored_code,
    input  unlock, fail, locked_out, busy, digit_count, fail_count, dbg_state
  );

  modport slave (
    input  digit_valid, digit, clear, stored_code,
    output unlock, fail, locked_out, busy, digit_count, fail_count, dbg_state
  );

endinterface

// File: rtl/code_entry_verifier_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Down-counter that measures a fixed hold time of CYCLES clock cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load CYCLES-1 and begin counting (one-cycle strobe)
//   o_done     : high during the last cycle of the hold (count reached 0)
// The owner leaves its hold state on the edge where o_done is high, so the
// hold state lasts CYCLES cycles counted from the start edge.
// ---------------------------------------------------------------------------
module hold_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_done
);

  // A one-cycle hold still needs a 1-bit counter.
  localparam int            W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0]  LOAD = W'(CYCLES - 1);

  logic [W-1:0] r_count;
  logic         r_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_count  <= LOAD;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - W'(1);
      end
    end
  end

  assign o_done = r_active && (r_count == '0);

endmodule

// File: rtl/code_entry_verifier.sv
// ---------------------------------------------------------------------------
// code_entry_verifier
// Collects CODE_DIGITS keypad nibbles (MSB first), de-scrambles the stored
// code and compares. Match -> GRANT (unlock held GRANT_CYCLES cycles);
// mismatch -> DENY (one-cycle fail). MAX_ATTEMPTS consecutive failures
// enter LOCKOUT for LOCKOUT_CYCLES cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : code_entry_verifier_if.slave (digit_valid, digit, clear,
//                stored_code in; unlock, fail, locked_out, busy,
//                digit_count, fail_count, dbg_state out)
// All outputs decode registered state/counters only.
// ---------------------------------------------------------------------------
module code_entry_verifier
  import code_entry_verifier_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,    // 1..3, fail_count is 2 bits
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int GRANT_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  code_entry_verifier_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_entry;
  logic [2:0]        r_digit_count;
  logic [1:0]        r_fail_count;

  logic w_entry_window;
  logic w_clear;
  logic w_accept;
  logic w_last_digit;
  logic w_match;
  logic w_lockout_due;
  logic w_grant_start;
  logic w_lock_start;
  logic w_grant_done;
  logic w_lock_done;
  logic w_unlock;
  logic w_fail;
  logic w_locked_out;
  logic w_busy;

  // Inputs are only looked at while an entry can be in progress.
  assign w_entry_window = (r_state == S_IDLE) || (r_state == S_COLLECT);
  assign w_clear        = w_entry_window && bus.clear;
  assign w_accept       = w_entry_window && bus.digit_valid && !bus.clear;
  assign w_last_digit   = w_accept && (r_digit_count == 3'(CODE_DIGITS - 1));

  // stored_code is sampled only here, so a reload during entry is honoured.
  assign w_match        = (r_entry == unscramble_code(bus.stored_code));

  // In DENY the counter already holds the post-failure value.
  assign w_lockout_due  = (r_fail_count == 2'(MAX_ATTEMPTS));

  assign w_grant_start  = (r_state == S_CHECK) && w_match;
  assign w_lock_start   = (r_state == S_DENY) && w_lockout_due;

  hold_timer #(.CYCLES(GRANT_CYCLES)) u_grant_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_grant_start),
    .o_done  (w_grant_done)
  );

  hold_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lock_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_lock_start),
    .o_done  (w_lock_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_unlock     = 1'b0;
    w_fail       = 1'b0;
    w_locked_out = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_clear)           w_state_nxt = S_IDLE;
        else if (w_last_digit) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_busy      = 1'b1;
        w_state_nxt = w_match ? S_GRANT : S_DENY;
      end
      S_GRANT: begin
        w_busy   = 1'b1;
        w_unlock = 1'b1;
        if (w_grant_done) w_state_nxt = S_IDLE;
      end
      S_DENY: begin
        w_busy      = 1'b1;
        w_fail      = 1'b1;
        w_state_nxt = w_lockout_due ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        w_busy       = 1'b1;
        w_locked_out = 1'b1;
        if (w_lock_done) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Entry shift register and digit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry       <= '0;
      r_digit_count <= 3'd0;
    end else if (w_clear || (r_state == S_CHECK)) begin
      r_entry       <= '0;
      r_digit_count <= 3'd0;
    end else if (w_accept) begin
      r_entry       <= {r_entry[CODE_W-5:0], bus.digit};
      r_digit_count <= r_digit_count + 3'd1;
    end
  end

  // Consecutive-failure counter: updated on leaving CHECK so fail_count
  // already shows the new value while fail is high. It cannot pass
  // MAX_ATTEMPTS because reaching it forces LOCKOUT, which clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_count <= 2'd0;
    end else if (r_state == S_CHECK) begin
      r_fail_count <= w_match ? 2'd0 : (r_fail_count + 2'd1);
    end else if ((r_state == S_LOCKOUT) && w_lock_done) begin
      r_fail_count <= 2'd0;
    end
  end

  assign bus.unlock      = w_unlock;
  assign bus.fail        = w_fail;
  assign bus.locked_out  = w_locked_out;
  assign bus.busy        = w_busy;
  assign bus.digit_count = r_digit_count;
  assign bus.fail_count  = r_fail_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_code_entry_verifier.sv
// ---------------------------------------------------------------------------
// tb_code_entry_verifier
// Scoreboard bench: the driver computes each entry's outcome from the code
// rules (rotate-right-by-a-nibble, MSB-first digits, consecutive-failure
// count) and queues the expected output events (kind, fail_count, length,
// first cycle). A monitor measures every unlock/fail/locked_out pulse and
// compares it against the queue head.
// ---------------------------------------------------------------------------
module tb_code_entry_verifier;

  localparam int MAX_ATTEMPTS   = 3;
  localparam int LOCKOUT_CYCLES = 1000;
  localparam int GRANT_CYCLES   = 8;
  localparam int IDLE_TIMEOUT   = LOCKOUT_CYCLES + GRANT_CYCLES + 20;
  localparam int W              = 48;
  localparam int K_GRANT        = 1;
  localparam int K_DENY         = 2;
  localparam int K_LOCK         = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  code_entry_verifier_if bus ();

  code_entry_verifier #(
    .MAX_ATTEMPTS   (MAX_ATTEMPTS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .GRANT_CYCLES   (GRANT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;
  int           m_digits[$];
  int           m_fails;
  logic [15:0]  cur_code;

  function automatic logic [W-1:0] pack(input int kind, input int fc, input int len, input int start);
    logic [1:0]  k2;
    logic [1:0]  f2;
    logic [11:0] l12;
    k2  = 2'(kind);
    f2  = 2'(fc);
    l12 = 12'(len);
    return {k2, f2, l12, start};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic mon_pu, mon_pf, mon_pl;
  int   g_start, g_len, g_fc;
  int   f_start, f_len, f_fc;
  int   l_start, l_len, l_fc;

  task automatic score_event(input int kind, input int fc, input int len, input int start);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = pack(kind, fc, len, start);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected event 0x%0h (kind %0d fc %0d len %0d start %0d), expected none",
               act, kind, fc, len, start);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL event: got 0x%0h (kind %0d fc %0d len %0d start %0d), expected 0x%0h",
                 act, kind, fc, len, start, exp);
      end
    end
  endtask

  initial begin
    mon_pu = 1'b0; mon_pf = 1'b0; mon_pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pu = 1'b0; mon_pf = 1'b0; mon_pl = 1'b0;
      end else begin
        if (bus.unlock && !mon_pu) begin
          g_start = cyc; g_len = 1; g_fc = int'(bus.fail_count);
        end else if (bus.unlock) begin
          g_len++;
        end else if (mon_pu) begin
          score_event(K_GRANT, g_fc, g_len, g_start);
        end
        if (bus.fail && !mon_pf) begin
          f_start = cyc; f_len = 1; f_fc = int'(bus.fail_count);
        end else if (bus.fail) begin
          f_len++;
        end else if (mon_pf) begin
          score_event(K_DENY, f_fc, f_len, f_start);
        end
        if (bus.locked_out && !mon_pl) begin
          l_start = cyc; l_len = 1; l_fc = int'(bus.fail_count);
        end else if (bus.locked_out) begin
          l_len++;
        end else if (mon_pl) begin
          score_event(K_LOCK, l_fc, l_len, l_start);
        end
        mon_pu = bus.unlock;
        mon_pf = bus.fail;
        mon_pl = bus.locked_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < IDLE_TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", n);
    end
  endtask

  // which: 0 = unlock, 1 = locked_out
  task automatic wait_high(input int which);
    int   n;
    logic s;
    n = 0;
    s = (which == 0) ? bus.unlock : bus.locked_out;
    while (!s && n < 20) begin
      @(negedge clk);
      n++;
      s = (which == 0) ? bus.unlock : bus.locked_out;
    end
    if (!s) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_high%0d: signal=0 after %0d cycles, expected 1", which, n);
    end
  endtask

  task automatic set_code(input logic [15:0] c);
    wait_idle();
    cur_code        = c;
    bus.stored_code = c;
  endtask

  task automatic send_digit(input logic [3:0] d);
    int entry;
    int plain;
    wait_idle();
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    @(negedge clk);
    bus.digit_valid = 1'b0;
    m_digits.push_back(int'(d));
    check("digit_count", 32'(bus.digit_count), 32'(m_digits.size()));
    if (m_digits.size() == 4) begin
      entry = ((m_digits[0] * 16 + m_digits[1]) * 16 + m_digits[2]) * 16 + m_digits[3];
      plain = (int'(cur_code) % 16) * 4096 + int'(cur_code) / 16;
      if (entry == plain) begin
        m_fails = 0;
        exp_q.push_back(pack(K_GRANT, 0, GRANT_CYCLES, cyc + 1));
      end else begin
        m_fails++;
        exp_q.push_back(pack(K_DENY, m_fails, 1, cyc + 1));
        if (m_fails == MAX_ATTEMPTS) begin
          exp_q.push_back(pack(K_LOCK, m_fails, LOCKOUT_CYCLES, cyc + 2));
          m_fails = 0;
        end
      end
      m_digits.delete();
    end
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    send_digit(4'(a));
    send_digit(4'(b));
    send_digit(4'(c));
    send_digit(4'(d));
  endtask

  task automatic do_clear(input logic with_digit);
    wait_idle();
    bus.clear       = 1'b1;
    bus.digit_valid = with_digit;
    bus.digit       = 4'($urandom_range(0, 15));
    @(negedge clk);
    bus.clear       = 1'b0;
    bus.digit_valid = 1'b0;
    m_digits.delete();
    check("clear_digit_count", 32'(bus.digit_count), 32'd0);
  endtask

  // Pulses that land while busy must be ignored; called at a negedge.
  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.busy) begin
        bus.digit       = 4'($urandom_range(0, 15));
        bus.digit_valid = 1'b1;
        bus.clear       = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        check("busy_digit_count", 32'(bus.digit_count), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic do_reset();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.clear       = 1'b0;
    exp_q.delete();
    m_digits.delete();
    m_fails = 0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] out_word();
    return 32'({bus.unlock, bus.fail, bus.locked_out, bus.busy, bus.digit_count, bus.fail_count});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          pl;
    int          dg[4];
    logic [15:0] c_final;
    logic [15:0] c_init;
    int          mode;

    cyc             = 0;
    n_vec           = 0;
    n_err           = 0;
    cur_code        = 16'h0000;
    bus.stored_code = 16'h0000;
    do_reset();
    check("reset_outputs", out_word(), 32'd0);

    // Correct code: 0x2341 stores plain 0x1234.
    set_code(16'h2341);
    enter4(1, 2, 3, 4);
    wait_idle();
    check("grant_fail_count", 32'(bus.fail_count), 32'd0);

    // Lockout after three wrong entries; digits during lockout ignored.
    enter4(1, 2, 3, 5); noise(2);
    enter4(1, 2, 3, 5); noise(2);
    enter4(1, 2, 3, 5);
    wait_high(1);
    noise(5);
    wait_idle();
    check("post_lock_outputs", out_word(), 32'd0);

    // Two failures then success.
    enter4(0, 0, 0, 0);
    enter4(4, 3, 2, 1);
    wait_idle();
    check("two_fail_count", 32'(bus.fail_count), 32'd2);
    enter4(1, 2, 3, 4);
    wait_idle();
    check("recover_fail_count", 32'(bus.fail_count), 32'd0);

    // Clear mid-entry, then clear with a coincident digit.
    send_digit(4'd9); send_digit(4'd9);
    do_clear(1'b0);
    enter4(1, 2, 3, 4);
    wait_idle();
    check("clear_fail_count", 32'(bus.fail_count), 32'd0);
    send_digit(4'd7);
    do_clear(1'b1);
    do_clear(1'b1);

    // Digits during GRANT, then four fresh digits required.
    enter4(1, 2, 3, 4);
    wait_high(0);
    noise(3);
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    repeat (3) @(negedge clk);
    check("fresh_digit_count", 32'(bus.digit_count), 32'd3);
    send_digit(4'd4);

    // Reset at cycle 500 of a lockout.
    enter4(8, 8, 8, 8);
    enter4(8, 8, 8, 8);
    enter4(8, 8, 8, 8);
    wait_high(1);
    repeat (499) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_digits.delete();
    m_fails = 0;
    #1;
    check("midlock_reset_outputs", out_word(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enter4(1, 2, 3, 4);

    // Randomized entries, with code reloads, aborted prefixes and noise.
    for (int t = 0; t < 40; t++) begin
      c_final = 16'($urandom_range(0, 65535));
      c_init  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : c_final;
      pl      = (int'(c_final) % 16) * 4096 + int'(c_final) / 16;
      mode    = $urandom_range(0, 3);
      for (int k = 0; k < 4; k++) begin
        dg[k] = (mode < 2) ? (pl >> (12 - 4 * k)) % 16 : $urandom_range(0, 15);
      end
      set_code(c_init);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) send_digit(4'($urandom_range(0, 15)));
        do_clear(1'($urandom_range(0, 1)));
      end
      send_digit(4'(dg[0]));
      send_digit(4'(dg[1]));
      set_code(c_final);
      send_digit(4'(dg[2]));
      send_digit(4'(dg[3]));
      noise($urandom_range(0, 3));
    end

    // Drain and close out.
    wait_idle();
    repeat (GRANT_CYCLES + 4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/code_entry_verifier.md
# code_entry_verifier

Reader-side counterpart of the stored-code register: collects four keypad nibbles, de-scrambles the register's 16-bit stored code, and compares. It drives unlock on a match and fail on a mismatch, counts consecutive failures, and enforces a timed lockout. It sits between the keypad debouncer and the lock actuator/status LEDs, reading `dataout` of the stored-code register.

## Interface
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout (≥1).
- LOCKOUT_CYCLES, 1000: clk cycles spent in LOCKOUT (≥2).
- GRANT_CYCLES, 8: clk cycles unlock is held high (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- digit_valid  in  1  one-cycle strobe; digit accepted when high at a rising edge in IDLE/COLLECT.
- digit  in  4  keypad nibble; all values 0x0–0xF are legal.
- clear  in  1  abandon the current entry.
- stored_code  in  16  scrambled code from the stored-code register.
- unlock  out  1  high in GRANT.
- fail  out  1  one-cycle pulse in DENY.
- locked_out  out  1  high in LOCKOUT.
- busy  out  1  high in CHECK, GRANT, DENY, or LOCKOUT.
- digit_count  out  3  digits held, 0–4.
- fail_count  out  2  consecutive failures, 0..MAX_ATTEMPTS.

## Operation
- Outputs are decoded from registered state and counters only; there is no combinational input→output path.
- Reset values: state IDLE; unlock, fail, locked_out, busy = 0; digit_count = 0; fail_count = 0; entry buffer = 0.
- De-scramble: plain = {stored_code[3:0], stored_code[15:4]}, which inverts the register's nibble permutation.
- Entry order is MSB first: digit 1 → entry[15:12] … digit 4 → entry[3:0].
- IDLE → COLLECT on the first accepted digit (digit_count = 1).
- COLLECT:
  - Each accepted digit increments digit_count.
  - The 4th digit moves to CHECK.
  - clear returns to IDLE with digit_count = 0 and consumes no attempt.
  - clear and digit_valid in the same cycle: clear wins and the digit is dropped.
- CHECK (1 cycle): compares the entry with the de-scrambled stored_code sampled that cycle. Match → GRANT; otherwise → DENY. digit_count clears on exit.
- GRANT: unlock high for GRANT_CYCLES cycles; fail_count clears on entry; then → IDLE.
- DENY (1 cycle): fail = 1 and fail_count increments.
  - If the new fail_count == MAX_ATTEMPTS → LOCKOUT.
  - Otherwise → IDLE.
- LOCKOUT: locked_out high for LOCKOUT_CYCLES cycles; then → IDLE with fail_count = 0.
- digit_valid and clear are ignored in CHECK, GRANT, DENY, and LOCKOUT.
- The stored_code value is used only in CHECK. A reload of the stored-code register during entry is therefore honoured if it completes before CHECK.
- Asserting rst_n low in any state, including mid-lockout or mid-grant, returns immediately to reset values. Lockout is not persistent across reset.

## Timing
- Edge E accepts the 4th digit; state = CHECK after E.
- unlock or fail asserts after edge E+1.
- unlock spans edges E+1 … E+GRANT_CYCLES; IDLE follows after edge E+GRANT_CYCLES+1.
- fail is high for exactly one cycle after E+1.
- locked_out rises after E+2 and stays high for exactly LOCKOUT_CYCLES cycles.
- The earliest next digit is accepted at the first edge at which the state is IDLE.
- Lockout counter width: $clog2(LOCKOUT_CYCLES). It counts down from LOCKOUT_CYCLES−1 and leaves LOCKOUT on 0.
- The GRANT timer works the same way.

## Structure
- The shared team parameters header holds:
  - the state encoding (IDLE, COLLECT, CHECK, GRANT, DENY, LOCKOUT, 3 bits);
  - CODE_DIGITS = 4;
  - the `unscramble_code` function, kept next to the matching scramble definition so both change together.
- Sub-module `hold_timer`:
  - parameterised down-counter with load/start, count, and done;
  - one instance for GRANT, one for LOCKOUT.
- The FSM, entry shift register, and fail counter live in the top module.

## Test plan
- Correct code:
  - Stimulus: stored_code = 0x2341; enter 1,2,3,4.
  - Response: unlock high for 8 cycles starting E+1; fail never asserts; fail_count = 0.
- Lockout:
  - Stimulus: stored_code = 0x2341; enter 1,2,3,5 three times.
  - Response: three fail pulses with fail_count 1, 2, 3; locked_out high for exactly 1000 cycles; digits sent during lockout are ignored; fail_count = 0 afterwards.
- Failure then success:
  - Stimulus: two wrong entries, then 1,2,3,4.
  - Response: unlock asserts and fail_count returns to 0.
- Clear mid-entry:
  - Stimulus: enter 9,9; assert clear; enter 1,2,3,4.
  - Response: grant occurs and fail_count stays 0.
  - Stimulus: clear and digit_valid in the same cycle.
  - Response: digit_count = 0.
- Reset mid-lockout:
  - Stimulus: reach lockout; pull rst_n low at cycle 500 of the lockout.
  - Response: locked_out = 0 immediately; all outputs at reset values; next entry of 1,2,3,4 grants.
- Input during GRANT:
  - Stimulus: digit_valid pulses while in GRANT.
  - Response: digit_count stays 0; after GRANT ends, four fresh digits are required.
